// File: rtl/encoder_pkg.sv
// encoder_pkg: shared state type and sizing constants for the serial 8:3 encoder
package encoder_pkg;
   typedef enum logic {IDLE, EMIT} state_t;
   localparam int ENC_WIDTH = 8;
   localparam int ENC_IDX_W = 3;
endpackage

// File: rtl/lowest_set_encoder_three.sv
// lowest_set_encoder_three: combinational 8:3 priority encoder, lowest set bit wins
module lowest_set_encoder_three
   import encoder_pkg::*;
(
   input  logic [ENC_WIDTH-1:0] vec,
   output logic [ENC_IDX_W-1:0] idx,
   output logic                 any
);
   always_comb begin
      idx = vec[0] ? 3'd0 : vec[1] ? 3'd1 : vec[2] ? 3'd2 : vec[3] ? 3'd3 :
            vec[4] ? 3'd4 : vec[5] ? 3'd5 : vec[6] ? 3'd6 : vec[7] ? 3'd7 : 3'd0;
      any = |vec;
   end
endmodule

// File: rtl/serial_encoder_three.sv
// serial_encoder_three: serializes a multi-hot vector into one index per handshake, lowest first.
// Optional SERIAL_ENCODER_ZERO_ERR_EN adds an err pulse when a zero vector is accepted.
module serial_encoder_three
   import encoder_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ENC_WIDTH-1:0] in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ENC_IDX_W-1:0] out_idx,
   output logic                 out_last,
   output logic                 busy
`ifdef SERIAL_ENCODER_ZERO_ERR_EN
   ,
   output logic                 err
`endif
);
   state_t                 state, state_nxt;
   logic [ENC_WIDTH-1:0]   pending, pending_nxt, rest;
   logic                   any, in_fire, out_fire;

   lowest_set_encoder_three u_lse (
      .vec (pending),
      .idx (out_idx),
      .any (any)
   );

   // rest is pending with its lowest set bit removed, i.e. with bit out_idx cleared
   always_comb begin
      rest        = pending & (pending - 8'd1);
      out_last    = any && (rest == '0);
      in_ready    = rst_n && (state == IDLE);
      out_valid   = rst_n && (state == EMIT);
      busy        = (state == EMIT);
      in_fire     = in_valid && in_ready;
      out_fire    = out_valid && out_ready;
      state_nxt   = state;
      pending_nxt = pending;
      if (in_fire && in_vec != '0) begin
         pending_nxt = in_vec;
         state_nxt   = EMIT;
      end
      if (out_fire) begin
         pending_nxt = rest;
         state_nxt   = out_last ? IDLE : EMIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
      end
   end

`ifdef SERIAL_ENCODER_ZERO_ERR_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         err <= 1'b0;
      else
         err <= in_fire && (in_vec == '0);
   end
`endif
endmodule

// File: tb/tb_serial_encoder_three.sv
// tb_serial_encoder_three: randomized self-checking bench with a bit-list reference model
module tb_serial_encoder_three;
   logic       clk = 0;
   logic       rst_n = 0;
   logic       in_valid = 0;
   logic       in_ready;
   logic [7:0] in_vec = 0;
   logic       out_valid;
   logic       out_ready = 0;
   logic [2:0] out_idx;
   logic       out_last;
   logic       busy;
`ifdef SERIAL_ENCODER_ZERO_ERR_EN
   logic       err;
`endif
   int checks = 0;
   int errors = 0;

   serial_encoder_three dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
`ifdef SERIAL_ENCODER_ZERO_ERR_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_held: in_ready=%0b out_valid=%0b expected 0 0", in_ready, out_valid);
      end
      rst_n = 1;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, out_last, out_idx} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_release: rdy=%0b vld=%0b busy=%0b last=%0b idx=%0d expected 1 0 0 0 0",
                  in_ready, out_valid, busy, out_last, out_idx);
      end
`ifdef SERIAL_ENCODER_ZERO_ERR_EN
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: err=%0b expected 0", err);
      end
`endif
   endtask

   // mode 0: out_ready always high, 1: pattern 1,0,0 repeating, 2: random
   task automatic run_vec(input logic [7:0] v, input int mode, input logic [7:0] garbage);
      int exp_q[$];
      int hs, cyc;
      logic rdy;
      for (int i = 0; i < 8; i++) if (v[i]) exp_q.push_back(i);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_before: in_ready=%0b expected 1 (vec %h)", in_ready, v);
      end
      in_valid = 1;
      in_vec   = v;
      @(negedge clk);
      in_valid = 0;
      in_vec   = garbage;
      if (exp_q.size() == 0) begin
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_vec: vld=%0b rdy=%0b busy=%0b expected 0 1 0", out_valid, in_ready, busy);
         end
`ifdef SERIAL_ENCODER_ZERO_ERR_EN
         checks++;
         if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse: err=%0b expected 1", err);
         end
         @(negedge clk);
         checks++;
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_width: err=%0b expected 0", err);
         end
`endif
         return;
      end
      hs  = 0;
      cyc = 0;
      while (hs < exp_q.size() && cyc < 64) begin
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL emit_ctrl: vld=%0b busy=%0b rdy=%0b expected 1 1 0 (vec %h beat %0d)",
                     out_valid, busy, in_ready, v, hs);
         end
         checks++;
         if (out_idx !== 3'(exp_q[hs]) || out_last !== (hs == exp_q.size() - 1)) begin
            errors++;
            $display("FAIL emit_idx: idx=%0d last=%0b expected %0d %0b (vec %h beat %0d)",
                     out_idx, out_last, exp_q[hs], hs == exp_q.size() - 1, v, hs);
         end
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
         out_ready = rdy;
         if (rdy) hs++;
         cyc++;
         @(negedge clk);
      end
      out_ready = 0;
      checks++;
      if (hs != exp_q.size()) begin
         errors++;
         $display("FAIL emit_timeout: beats=%0d expected %0d", hs, exp_q.size());
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL emit_done: rdy=%0b vld=%0b busy=%0b expected 1 0 0 (vec %h)",
                  in_ready, out_valid, busy, v);
      end
      if (mode == 0) begin
         checks++;
         if (cyc != exp_q.size()) begin
            errors++;
            $display("FAIL emit_cycles: cycles=%0d expected %0d", cyc, exp_q.size());
         end
      end
   endtask

   task automatic test_directed();
      run_vec(8'b1010_0100, 0, 8'h00);
      run_vec(8'h80, 0, 8'h00);
      run_vec(8'hFF, 1, 8'h00);
      run_vec(8'h00, 0, 8'h00);
   endtask

   task automatic test_busy_ignore();
      run_vec(8'h03, 0, 8'hFF);
      run_vec(8'h03, 2, 8'hFF);
   endtask

   task automatic test_reset_mid_emit();
      int seen;
      @(negedge clk);
      in_valid = 1;
      in_vec   = 8'h0F;
      @(negedge clk);
      in_valid  = 0;
      out_ready = 1;
      @(negedge clk);
      checks++;
      if (out_idx !== 3'd1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: idx=%0d vld=%0b expected 1 1", out_idx, out_valid);
      end
      @(negedge clk);
      rst_n     = 0;
      out_ready = 0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || dut.pending !== 8'h00 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: vld=%0b pending=%h rdy=%0b expected 0 00 0", out_valid, dut.pending, in_ready);
      end
      rst_n     = 1;
      out_ready = 1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_release: in_ready=%0b expected 1", in_ready);
      end
      seen = 0;
      repeat (6) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      out_ready = 0;
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL mid_abandon: beats=%0d expected 0", seen);
      end
   endtask

   task automatic test_random();
      logic [7:0] v;
      for (int n = 0; n < 40; n++) begin
         v = (n % 8 == 7) ? 8'h00 : 8'($urandom);
         run_vec(v, int'($urandom_range(0, 2)), 8'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_ignore();
      test_reset_mid_emit();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
